// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: front-end controller for the digital clock core.
//
// Turns three debounced push-button pulses into the core's run enable and
// time/alarm load interface. It also owns the buzzer, which is started by a
// rising edge of the core's alarm output and stopped by timeout, snooze or
// dismiss.
//
// Ports:
//   clock       in   system clock, rising-edge
//   reset       in   asynchronous active-low reset
//   btn_mode    in   pulse: advance edit state / dismiss a ringing alarm
//   btn_inc     in   pulse: increment the field being edited
//   btn_snooze  in   pulse: snooze a ringing alarm
//   alarm_en    in   level: 0 silences and blocks the alarm
//   alarm_in    in   level: alarm match from the clock core
//   enable      out  run enable to the core (0 while the time is edited)
//   r_m         out  one-cycle load strobe: 1 = r_time is the new current time
//   r_time      out  BCD hh:mm, 12-hour format
//   am_sel      out  AM flag accompanying r_time
//   edit_state  out  0 RUN, 1 T_HR, 2 T_MIN, 3 A_HR, 4 A_MIN
//   buzzer      out  alarm sounder drive
module clock_set_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_snooze,
    input  logic        alarm_en,
    input  logic        alarm_in,
    output logic        enable,
    output logic        r_m,
    output logic [15:0] r_time,
    output logic        am_sel,
    output logic [2:0]  edit_state,
    output logic        buzzer
);

    localparam int unsigned PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int unsigned SEC_W    = (MAX_SECS > 1) ? $clog2(MAX_SECS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_DIV - 1);
    localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SECS - 1);
    localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);

    typedef enum logic [2:0] {
        StRun  = 3'd0,
        StTHr  = 3'd1,
        StTMin = 3'd2,
        StAHr  = 3'd3,
        StAMin = 3'd4
    } edit_e;

    typedef enum logic [1:0] {
        RingQuiet  = 2'd0,
        RingOn     = 2'd1,
        RingSnooze = 2'd2
    } ring_e;

    // 12-hour BCD hour increment, 12 wraps to 01.
    function automatic logic [7:0] hr_inc(input logic [7:0] hr);
        logic [7:0] r;
        if (hr == 8'h12) begin
            r = 8'h01;
        end else if (hr[3:0] == 4'd9) begin
            r = 8'h10;
        end else begin
            r = {hr[7:4], hr[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD minute increment, 59 wraps to 00 without carrying into hours.
    function automatic logic [7:0] min_inc(input logic [7:0] mn);
        logic [7:0] r;
        if (mn == 8'h59) begin
            r = 8'h00;
        end else if (mn[3:0] == 4'd9) begin
            r = {mn[7:4] + 4'd1, 4'd0};
        end else begin
            r = {mn[7:4], mn[3:0] + 4'd1};
        end
        return r;
    endfunction

    edit_e            edit_q, edit_d;
    ring_e            ring_q, ring_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [7:0]       t_hr_q, t_hr_d, t_min_q, t_min_d;
    logic [7:0]       a_hr_q, a_hr_d, a_min_q, a_min_d;
    logic             t_am_q, t_am_d, a_am_q, a_am_d;
    logic             r_m_q, r_m_d;
    logic             alarm_q;

    logic tick;
    logic alarm_rise;
    logic dismiss;
    logic mode_adv;
    logic inc_ok;
    logic show_time;

    // Prescaler and ring FSM.
    always_comb begin
        tick       = (pre_q == PRE_LAST);
        pre_d      = tick ? '0 : pre_q + 1'b1;
        alarm_rise = alarm_in & ~alarm_q;
        ring_d     = ring_q;
        sec_d      = sec_q;
        dismiss    = 1'b0;

        if (!alarm_en) begin
            ring_d = RingQuiet;
            sec_d  = '0;
        end else begin
            case (ring_q)
                RingQuiet: begin
                    sec_d = '0;
                    // Never start ringing while the user is editing.
                    if (alarm_rise && (edit_q == StRun)) begin
                        ring_d = RingOn;
                    end
                end
                RingOn: begin
                    if (btn_mode) begin
                        ring_d  = RingQuiet;
                        dismiss = 1'b1;
                        sec_d   = '0;
                    end else if (btn_snooze) begin
                        ring_d = RingSnooze;
                        sec_d  = '0;
                    end else if (tick) begin
                        if (sec_q == RING_LAST) begin
                            ring_d = RingQuiet;
                            sec_d  = '0;
                        end else begin
                            sec_d = sec_q + 1'b1;
                        end
                    end
                end
                RingSnooze: begin
                    if (tick) begin
                        if (sec_q == SNOOZE_LAST) begin
                            ring_d = RingOn;
                            sec_d  = '0;
                        end else begin
                            sec_d = sec_q + 1'b1;
                        end
                    end
                end
                default: begin
                    ring_d = RingQuiet;
                    sec_d  = '0;
                end
            endcase
        end
    end

    // Edit FSM and shadow registers.
    always_comb begin
        // A dismissing btn_mode is consumed by the ring FSM.
        mode_adv = btn_mode & ~dismiss;
        inc_ok   = btn_inc & ~btn_mode;
        edit_d   = edit_q;
        t_hr_d   = t_hr_q;
        t_min_d  = t_min_q;
        t_am_d   = t_am_q;
        a_hr_d   = a_hr_q;
        a_min_d  = a_min_q;
        a_am_d   = a_am_q;
        r_m_d    = 1'b0;

        if (mode_adv) begin
            r_m_d = (edit_q == StTMin);
            case (edit_q)
                StRun:   edit_d = StTHr;
                StTHr:   edit_d = StTMin;
                StTMin:  edit_d = StAHr;
                StAHr:   edit_d = StAMin;
                StAMin:  edit_d = StRun;
                default: edit_d = StRun;
            endcase
        end else if (inc_ok) begin
            case (edit_q)
                StTHr: begin
                    t_hr_d = hr_inc(t_hr_q);
                    if (t_hr_q == 8'h11) t_am_d = ~t_am_q;
                end
                StTMin: t_min_d = min_inc(t_min_q);
                StAHr: begin
                    a_hr_d = hr_inc(a_hr_q);
                    if (a_hr_q == 8'h11) a_am_d = ~a_am_q;
                end
                StAMin: a_min_d = min_inc(a_min_q);
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edit_q  <= StRun;
            ring_q  <= RingQuiet;
            pre_q   <= '0;
            sec_q   <= '0;
            t_hr_q  <= 8'h12;
            t_min_q <= 8'h00;
            t_am_q  <= 1'b1;
            a_hr_q  <= 8'h06;
            a_min_q <= 8'h00;
            a_am_q  <= 1'b1;
            r_m_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            edit_q  <= edit_d;
            ring_q  <= ring_d;
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            t_hr_q  <= t_hr_d;
            t_min_q <= t_min_d;
            t_am_q  <= t_am_d;
            a_hr_q  <= a_hr_d;
            a_min_q <= a_min_d;
            a_am_q  <= a_am_d;
            r_m_q   <= r_m_d;
            alarm_q <= alarm_in;
        end
    end

    // The load cycle lands in A_HR but must still present the edited time.
    always_comb begin
        show_time  = r_m_q || (edit_q == StTHr) || (edit_q == StTMin);
        enable     = !((edit_q == StTHr) || (edit_q == StTMin));
        r_m        = r_m_q;
        r_time     = show_time ? {t_hr_q, t_min_q} : {a_hr_q, a_min_q};
        am_sel     = show_time ? t_am_q : a_am_q;
        edit_state = edit_q;
        buzzer     = (ring_q == RingOn);
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: the driver pushes the reference model's
// expected outputs for every clock edge; an independent monitor pops and
// compares them shortly after each rising edge.
module tb_clock_set_ctrl;

    localparam int unsigned CLK_DIV     = 2;
    localparam int unsigned RING_SECS   = 4;
    localparam int unsigned SNOOZE_SECS = 3;

    logic        clock;
    logic        reset;
    logic        btn_mode, btn_inc, btn_snooze, alarm_en, alarm_in;
    logic        enable, r_m, am_sel, buzzer;
    logic [15:0] r_time;
    logic [2:0]  edit_state;

    clock_set_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_snooze(btn_snooze),
        .alarm_en  (alarm_en),
        .alarm_in  (alarm_in),
        .enable    (enable),
        .r_m       (r_m),
        .r_time    (r_time),
        .am_sel    (am_sel),
        .edit_state(edit_state),
        .buzzer    (buzzer)
    );

    typedef struct packed {
        logic        enable;
        logic        r_m;
        logic [15:0] r_time;
        logic        am_sel;
        logic [2:0]  edit_state;
        logic        buzzer;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain integers for hours/minutes, ring as a mode name.
    localparam int Quiet   = 0;
    localparam int Ringing = 1;
    localparam int Snoozed = 2;

    int m_edge, m_edit, m_ring, m_secs;
    int t_hr, t_min, a_hr, a_min;
    bit t_am, a_am, m_ain_prev, m_load;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] to_bcd(input int hr, input int mn);
        return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10)};
    endfunction

    task automatic model_reset();
        m_edge = 0; m_edit = 0; m_ring = Quiet; m_secs = 0;
        t_hr = 12; t_min = 0; t_am = 1'b1;
        a_hr = 6;  a_min = 0; a_am = 1'b1;
        m_ain_prev = 1'b0; m_load = 1'b0;
    endtask

    task automatic bump_hour(inout int hr, inout bit am);
        if (hr == 11) begin
            hr = 12;
            am = !am;
        end else if (hr == 12) begin
            hr = 1;
        end else begin
            hr = hr + 1;
        end
    endtask

    task automatic model_step(input bit mode, input bit inc, input bit snz, input bit en,
                              input bit ain);
        bit tick, rise, dismiss;
        m_edge++;
        tick = (m_edge % CLK_DIV) == 0;
        rise = ain && !m_ain_prev;
        m_ain_prev = ain;
        dismiss = 1'b0;
        if (!en) begin
            m_ring = Quiet;
        end else if (m_ring == Quiet) begin
            if (rise && m_edit == 0) begin
                m_ring = Ringing;
                m_secs = 0;
            end
        end else if (m_ring == Ringing) begin
            if (mode) begin
                m_ring = Quiet;
                dismiss = 1'b1;
            end else if (snz) begin
                m_ring = Snoozed;
                m_secs = 0;
            end else if (tick) begin
                m_secs++;
                if (m_secs == RING_SECS) m_ring = Quiet;
            end
        end else if (tick) begin
            m_secs++;
            if (m_secs == SNOOZE_SECS) begin
                m_ring = Ringing;
                m_secs = 0;
            end
        end
        m_load = 1'b0;
        if (mode && !dismiss) begin
            m_load = (m_edit == 2);
            m_edit = (m_edit + 1) % 5;
        end else if (inc && !mode) begin
            case (m_edit)
                1: bump_hour(t_hr, t_am);
                2: t_min = (t_min + 1) % 60;
                3: bump_hour(a_hr, a_am);
                4: a_min = (a_min + 1) % 60;
                default: begin
                end
            endcase
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        bit   show;
        show = m_load || m_edit == 1 || m_edit == 2;
        o.enable     = !(m_edit == 1 || m_edit == 2);
        o.r_m        = m_load;
        o.r_time     = show ? to_bcd(t_hr, t_min) : to_bcd(a_hr, a_min);
        o.am_sel     = show ? t_am : a_am;
        o.edit_state = 3'(m_edit);
        o.buzzer     = (m_ring == Ringing);
        return o;
    endfunction

    // Monitor: compares every presented output against the scoreboard.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {enable, r_m, r_time, am_sel, edit_state, buzzer};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got en=%b r_m=%b r_time=%h am=%b ed=%0d bz=%b exp en=%b r_m=%b r_time=%h am=%b ed=%0d bz=%b",
                             $time, a.enable, a.r_m, a.r_time, a.am_sel, a.edit_state, a.buzzer,
                             e.enable, e.r_m, e.r_time, e.am_sel, e.edit_state, e.buzzer);
                end
            end
        end
    end

    task automatic cycle(input bit mode, input bit inc, input bit snz, input bit en,
                         input bit ain);
        @(negedge clock);
        btn_mode = mode; btn_inc = inc; btn_snooze = snz; alarm_en = en; alarm_in = ain;
        model_step(mode, inc, snz, en, ain);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n, input bit en, input bit ain);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, en, ain);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic mode_press();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        obs_t a, e;
        e = {1'b1, 1'b0, 16'h0600, 1'b1, 3'd0, 1'b0};
        a = {enable, r_m, r_time, am_sel, edit_state, buzzer};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got en=%b r_m=%b r_time=%h am=%b ed=%0d bz=%b exp reset values",
                     tag, a.enable, a.r_m, a.r_time, a.am_sel, a.edit_state, a.buzzer);
        end
    endtask

    // Asserts reset away from the clock edge, checks outputs respond without
    // a clock, then releases it before the next driving negedge.
    task automatic do_reset(input string tag);
        @(posedge clock);
        #3;
        reset = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0; alarm_en = 1'b1; alarm_in = 1'b0;
        #1;
        check_reset(tag);
        @(posedge clock);
        #4;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        bit ain, en;
        reset = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0; alarm_en = 1'b1; alarm_in = 1'b0;
        model_reset();

        do_reset("reset_initial");
        idle(20, 1'b1, 1'b0);

        // Time edit to 03:10 and load.
        mode_press();
        incs(3);
        mode_press();
        incs(10);
        mode_press();
        idle(3, 1'b1, 1'b0);
        mode_press();
        mode_press();
        idle(2, 1'b1, 1'b0);

        // Minute wrap from 00.
        do_reset("reset_before_minwrap");
        mode_press();
        mode_press();
        incs(60);
        for (int i = 0; i < 3; i++) mode_press();

        // Hour 11 AM -> 12 PM -> 01 PM.
        do_reset("reset_before_hour");
        mode_press();
        incs(13);
        for (int i = 0; i < 4; i++) mode_press();
        idle(2, 1'b1, 1'b0);

        // Ring timeout with alarm_in held high.
        idle(3, 1'b1, 1'b0);
        idle(20, 1'b1, 1'b1);
        // Snooze then re-ring.
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(20, 1'b1, 1'b1);
        // Dismiss with btn_mode.
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5, 1'b1, 1'b1);
        // Edge with alarm disabled.
        idle(2, 1'b0, 1'b0);
        idle(10, 1'b0, 1'b1);

        // Reset mid-edit and while ringing.
        idle(2, 1'b1, 1'b0);
        mode_press();
        mode_press();
        incs(5);
        do_reset("reset_mid_edit");
        idle(2, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1);
        do_reset("reset_while_ringing");

        // Randomised traffic.
        ain = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 14) == 0) ain = !ain;
            en = ($urandom_range(0, 19) != 0);
            cycle($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0, en, ain);
            if (i % 1000 == 999) begin
                do_reset("reset_random");
                ain = 1'b0;
            end
        end

        @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
